// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage owning the PC, issuing single-outstanding bus
// reads, queueing returned words and discarding wrong-path data on redirect.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  stalled_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_addr_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);
    localparam int AW = $clog2(QDEPTH);

    typedef enum logic [1:0] {REQ, WAIT, KILL} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, addr_q, addr_d;
    logic        kill_q, kill_d;
    logic [31:0] qpc_q [QDEPTH];
    logic [31:0] qpc_d [QDEPTH];
    logic [31:0] qins_q [QDEPTH];
    logic [31:0] qins_d [QDEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic        push, pop;
    logic [31:0] tgt;
    logic        unused;

    assign unused       = ^{stalled_i[2:1], branch_addr_i[1:0]};
    assign tgt          = {branch_addr_i[31:2], 2'b00};
    assign ibus_req_o   = rst && state_q == REQ && cnt_q < (AW+1)'(QDEPTH);
    // A redirected-but-ungranted request keeps presenting its original address
    assign ibus_addr_o  = kill_q ? addr_q : pc_q;
    assign inst_valid_o = cnt_q != '0 && !branch_flag_i;
    assign inst_o       = inst_valid_o ? qins_q[rd_q] : 32'h0000_0013;
    assign inst_addr_o  = inst_valid_o ? qpc_q[rd_q] : 32'h0;
    assign pop          = inst_valid_o && !stalled_i[0];
    assign push         = state_q == WAIT && ibus_rvalid_i && !branch_flag_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        kill_d  = kill_q;
        qpc_d   = qpc_q;
        qins_d  = qins_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        case (state_q)
            REQ: begin
                if (ibus_req_o && ibus_gnt_i) begin
                    state_d = (kill_q || branch_flag_i) ? KILL : WAIT;
                    pc_d    = kill_q ? pc_q : pc_q + 32'd4;
                    kill_d  = 1'b0;
                end else if (ibus_req_o && branch_flag_i && !kill_q) begin
                    kill_d = 1'b1;
                    addr_d = pc_q;
                end
            end
            WAIT:    state_d = ibus_rvalid_i ? REQ : (branch_flag_i ? KILL : WAIT);
            KILL:    state_d = ibus_rvalid_i ? REQ : KILL;
            default: state_d = REQ;
        endcase
        // pc already advanced past the outstanding request while in WAIT
        if (push) begin
            qpc_d[wr_q]  = pc_q - 32'd4;
            qins_d[wr_q] = ibus_rdata_i;
            wr_d         = wr_q + 1'b1;
        end
        if (branch_flag_i) begin
            pc_d  = tgt;
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            rd_d  = pop ? rd_q + 1'b1 : rd_q;
            cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            kill_q  <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                qpc_q[i]  <= '0;
                qins_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            kill_q  <= kill_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            qpc_q   <= qpc_d;
            qins_q  <= qins_d;
        end
    end
endmodule
